// File: rtl/framebuffer_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : framebuffer_arbiter_if
// Description : Bundles the three traffic groups around the framebuffer
//               arbiter:
//                 - display side : line_request/line_base in,
//                                  pixel_data/valid/index, line_done and
//                                  line_overrun out, overrun_clear in
//                 - host side    : host_valid/address/data in, host_ready out
//                 - memory side  : mem_address/read/write/write_data out,
//                                  mem_ready/read_data in
//               The slave modport is the arbiter's view. The master modport
//               is the surrounding system (display, host and memory).
// Revision    : 1.0 - initial release
// ============================================================================
interface framebuffer_arbiter_if #(
    parameter int ADDR_WIDTH = 22,
    parameter int DATA_WIDTH = 12
);
    logic                  line_request;
    logic [ADDR_WIDTH-1:0] line_base;
    logic [DATA_WIDTH-1:0] pixel_data;
    logic                  pixel_valid;
    logic [9:0]            pixel_index;
    logic                  line_done;
    logic                  line_overrun;
    logic                  overrun_clear;
    logic                  host_valid;
    logic                  host_ready;
    logic [ADDR_WIDTH-1:0] host_address;
    logic [DATA_WIDTH-1:0] host_data;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic                  mem_read;
    logic                  mem_write;
    logic [DATA_WIDTH-1:0] mem_write_data;
    logic                  mem_ready;
    logic [DATA_WIDTH-1:0] mem_read_data;

    modport slave (
        input  line_request, line_base, overrun_clear,
        input  host_valid, host_address, host_data,
        input  mem_ready, mem_read_data,
        output pixel_data, pixel_valid, pixel_index, line_done, line_overrun,
        output host_ready,
        output mem_address, mem_read, mem_write, mem_write_data
    );

    modport master (
        output line_request, line_base, overrun_clear,
        output host_valid, host_address, host_data,
        output mem_ready, mem_read_data,
        input  pixel_data, pixel_valid, pixel_index, line_done, line_overrun,
        input  host_ready,
        input  mem_address, mem_read, mem_write, mem_write_data
    );
endinterface
`default_nettype wire

// File: rtl/framebuffer_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : framebuffer_arbiter
// Description : Shares a single-port pixel framebuffer between the display
//               line prefetcher (strict priority, one full line per request)
//               and the host pixel writer (buffered in a small FIFO, drained
//               between bursts).
// Ports       : clock - rising-edge clock
//               reset - asynchronous, active-low
//               bus   - framebuffer_arbiter_if.slave (display, host, memory)
// Revision    : 1.0 - initial release
// ============================================================================
module framebuffer_arbiter #(
    parameter int ADDR_WIDTH   = 22,
    parameter int DATA_WIDTH   = 12,
    parameter int LINE_PIXELS  = 640,
    parameter int READ_LATENCY = 2,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    framebuffer_arbiter_if.slave  bus
);

    localparam int c_cnt_w = (LINE_PIXELS > 1) ? $clog2(LINE_PIXELS) : 1;
    localparam int c_ptr_w = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [c_cnt_w-1:0] c_last_pixel = c_cnt_w'(LINE_PIXELS - 1);
    localparam logic [c_ptr_w:0]   c_fifo_full  = (c_ptr_w + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_BURST = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t                  r_state;
    logic                    r_pending;
    logic [ADDR_WIDTH-1:0]   r_pending_base;
    logic [c_cnt_w-1:0]      r_burst_count;
    logic [ADDR_WIDTH-1:0]   r_mem_address;
    logic                    r_mem_read;
    logic                    r_mem_write;
    logic [DATA_WIDTH-1:0]   r_mem_write_data;
    logic                    r_line_overrun;

    // Host write FIFO
    logic [ADDR_WIDTH-1:0]   r_fifo_addr [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]   r_fifo_data [FIFO_DEPTH];
    logic [c_ptr_w-1:0]      r_wr_ptr;
    logic [c_ptr_w-1:0]      r_rd_ptr;
    logic [c_ptr_w:0]        r_count;

    // Return path
    logic [READ_LATENCY-1:0] r_valid_pipe;
    logic [c_cnt_w-1:0]      r_ret_count;
    logic [DATA_WIDTH-1:0]   r_pixel_data;
    logic                    r_pixel_valid;
    logic [9:0]              r_pixel_index;
    logic                    r_line_done;

    logic                    w_host_ready;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_read_accept;
    logic                    w_return;

    // host_ready depends only on the occupancy; a pop in the same cycle
    // does not open a slot until the next cycle.
    assign w_host_ready  = (r_count != c_fifo_full);
    assign w_push        = bus.host_valid && w_host_ready;
    assign w_pop         = (r_state == ST_WRITE) && bus.mem_ready;
    assign w_read_accept = r_mem_read && bus.mem_ready;
    assign w_return      = r_valid_pipe[READ_LATENCY-1];

    // ------------------------------------------------------------------
    // Host FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= bus.host_address;
            r_fifo_data[r_wr_ptr] <= bus.host_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_ptr_w + 1)'(1);
                2'b01:   r_count <= r_count - (c_ptr_w + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Arbitration FSM with registered memory strobes
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state          <= ST_IDLE;
            r_pending        <= 1'b0;
            r_pending_base   <= '0;
            r_burst_count    <= '0;
            r_mem_address    <= '0;
            r_mem_read       <= 1'b0;
            r_mem_write      <= 1'b0;
            r_mem_write_data <= '0;
            r_line_overrun   <= 1'b0;
        end else begin
            // A request that arrives while a line is in flight is dropped;
            // clearing wins over a simultaneous new overrun.
            if (bus.overrun_clear)
                r_line_overrun <= 1'b0;
            else if (bus.line_request && (r_state == ST_BURST || r_state == ST_DRAIN))
                r_line_overrun <= 1'b1;

            case (r_state)
                ST_IDLE: begin
                    if (bus.line_request || r_pending) begin
                        r_state       <= ST_BURST;
                        r_pending     <= 1'b0;
                        r_mem_read    <= 1'b1;
                        r_burst_count <= '0;
                        r_mem_address <= bus.line_request ? bus.line_base : r_pending_base;
                    end else if (r_count != '0) begin
                        r_state          <= ST_WRITE;
                        r_mem_write      <= 1'b1;
                        r_mem_address    <= r_fifo_addr[r_rd_ptr];
                        r_mem_write_data <= r_fifo_data[r_rd_ptr];
                    end
                end
                ST_WRITE: begin
                    // Remember the request so the next IDLE visit starts the
                    // burst ahead of any further queued writes.
                    if (bus.line_request) begin
                        r_pending      <= 1'b1;
                        r_pending_base <= bus.line_base;
                    end
                    if (bus.mem_ready) begin
                        r_mem_write <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                ST_BURST: begin
                    if (bus.mem_ready) begin
                        if (r_burst_count == c_last_pixel) begin
                            r_mem_read <= 1'b0;
                            r_state    <= ST_DRAIN;
                        end else begin
                            r_burst_count <= r_burst_count + c_cnt_w'(1);
                            r_mem_address <= r_mem_address + ADDR_WIDTH'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (r_valid_pipe == '0) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Return path: one valid bit per accepted read, READ_LATENCY deep
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_valid_pipe  <= '0;
            r_ret_count   <= '0;
            r_pixel_data  <= '0;
            r_pixel_valid <= 1'b0;
            r_pixel_index <= '0;
            r_line_done   <= 1'b0;
        end else begin
            r_valid_pipe[0] <= w_read_accept;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_valid_pipe[i] <= r_valid_pipe[i-1];
            end
            r_pixel_valid <= w_return;
            r_line_done   <= w_return && (r_ret_count == c_last_pixel);
            if (w_return) begin
                r_pixel_data  <= bus.mem_read_data;
                r_pixel_index <= 10'(r_ret_count);
                r_ret_count   <= (r_ret_count == c_last_pixel) ? '0 : r_ret_count + c_cnt_w'(1);
            end
        end
    end

    assign bus.host_ready     = w_host_ready;
    assign bus.mem_address    = r_mem_address;
    assign bus.mem_read       = r_mem_read;
    assign bus.mem_write      = r_mem_write;
    assign bus.mem_write_data = r_mem_write_data;
    assign bus.pixel_data     = r_pixel_data;
    assign bus.pixel_valid    = r_pixel_valid;
    assign bus.pixel_index    = r_pixel_index;
    assign bus.line_done      = r_line_done;
    assign bus.line_overrun   = r_line_overrun;

endmodule
`default_nettype wire

// File: tb/tb_framebuffer_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_framebuffer_arbiter
// Description : Self-checking bench for framebuffer_arbiter. A transaction
//               scoreboard holds the expected memory operations and returned
//               pixels in order; a latency-modelled memory returns
//               addr[11:0] as read data.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_framebuffer_arbiter;

    localparam int c_addr_w = 22;
    localparam int c_data_w = 12;
    localparam int c_line   = 8;
    localparam int c_rl     = 2;
    localparam int c_depth  = 4;

    typedef struct {
        bit                    is_write;
        logic [c_addr_w-1:0]   addr;
        logic [c_data_w-1:0]   data;
        int                    n;
    } op_t;

    typedef struct {
        logic [c_data_w-1:0]   data;
        int                    index;
        bit                    done;
    } pix_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    framebuffer_arbiter_if #(.ADDR_WIDTH(c_addr_w), .DATA_WIDTH(c_data_w)) bus ();

    framebuffer_arbiter #(
        .ADDR_WIDTH  (c_addr_w),
        .DATA_WIDTH  (c_data_w),
        .LINE_PIXELS (c_line),
        .READ_LATENCY(c_rl),
        .FIFO_DEPTH  (c_depth)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    op_t  op_q [$];
    pix_t pix_q [$];
    op_t  mon_op;
    pix_t mon_pix;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   t_req = 0;
    bit   timing_en = 1'b0;
    bit   seen_pix3 = 1'b0;
    int   ready_mode = 0;
    int   ready_phase = 0;
    logic [c_data_w-1:0] rd_pipe [c_rl];

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model: expected transactions ----------------
    task automatic expect_burst(input logic [c_addr_w-1:0] base);
        logic [c_addr_w-1:0] a;
        for (int n = 0; n < c_line; n++) begin
            a = base + c_addr_w'(n);   // modulo 2^22
            op_q.push_back('{is_write: 1'b0, addr: a, data: '0, n: n});
            pix_q.push_back('{data: a[c_data_w-1:0], index: n, done: (n == c_line - 1)});
        end
    endtask

    task automatic expect_write(input logic [c_addr_w-1:0] a, input logic [c_data_w-1:0] d);
        op_q.push_back('{is_write: 1'b1, addr: a, data: d, n: 0});
    endtask

    // ---------------- environment: memory and ready generator ----------------
    always @(posedge clock) begin
        rd_pipe[0] <= (bus.mem_read && bus.mem_ready) ? bus.mem_address[c_data_w-1:0] : '0;
        for (int i = 1; i < c_rl; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bus.mem_read_data = rd_pipe[c_rl-1];

    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        bus.mem_ready = 1'b0;
        forever begin
            @(posedge clock);
            #2;
            case (ready_mode)
                0: bus.mem_ready = 1'b1;
                1: begin
                    bus.mem_ready = (ready_phase == 0);
                    ready_phase = (ready_phase + 1) % 3;
                end
                2: bus.mem_ready = 1'($urandom_range(0, 1));
                default: bus.mem_ready = 1'b0;
            endcase
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clock) begin
        if (reset) begin
            if (bus.mem_read || bus.mem_write)
                check_value("rw_exclusive", 32'(bus.mem_read & bus.mem_write), 32'd0);
            if (bus.mem_ready && (bus.mem_read || bus.mem_write)) begin
                check_value("op_expected", 32'(op_q.size() != 0), 32'd1);
                if (op_q.size() != 0) begin
                    mon_op = op_q.pop_front();
                    check_value("op_kind", 32'(bus.mem_write), 32'(mon_op.is_write));
                    check_value("op_addr", 32'(bus.mem_address), 32'(mon_op.addr));
                    if (mon_op.is_write)
                        check_value("op_wdata", 32'(bus.mem_write_data), 32'(mon_op.data));
                    else if (timing_en)
                        check_value("read_accept_cycle", 32'(cyc), 32'(t_req + mon_op.n));
                end
            end
            if (bus.pixel_valid) begin
                check_value("pix_expected", 32'(pix_q.size() != 0), 32'd1);
                if (pix_q.size() != 0) begin
                    mon_pix = pix_q.pop_front();
                    check_value("pix_data", 32'(bus.pixel_data), 32'(mon_pix.data));
                    check_value("pix_index", 32'(bus.pixel_index), 32'(mon_pix.index));
                    check_value("pix_done", 32'(bus.line_done), 32'(mon_pix.done));
                end
                if (bus.pixel_index == 10'd3) seen_pix3 = 1'b1;
                if (timing_en && bus.pixel_index == 10'd0)
                    check_value("first_pix_cycle", 32'(cyc), 32'(t_req + 1 + c_rl));
                if (timing_en && bus.line_done)
                    check_value("line_done_cycle", 32'(cyc), 32'(t_req + c_line + c_rl));
            end
            if (bus.line_done)
                check_value("done_with_valid", 32'(bus.pixel_valid), 32'd1);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic check_reset_outputs(input string pfx);
        check_value({pfx, "_host_ready"},     32'(bus.host_ready), 32'd1);
        check_value({pfx, "_mem_read"},       32'(bus.mem_read), 32'd0);
        check_value({pfx, "_mem_write"},      32'(bus.mem_write), 32'd0);
        check_value({pfx, "_pixel_valid"},    32'(bus.pixel_valid), 32'd0);
        check_value({pfx, "_line_done"},      32'(bus.line_done), 32'd0);
        check_value({pfx, "_line_overrun"},   32'(bus.line_overrun), 32'd0);
        check_value({pfx, "_mem_address"},    32'(bus.mem_address), 32'd0);
        check_value({pfx, "_mem_write_data"}, 32'(bus.mem_write_data), 32'd0);
        check_value({pfx, "_pixel_data"},     32'(bus.pixel_data), 32'd0);
        check_value({pfx, "_pixel_index"},    32'(bus.pixel_index), 32'd0);
    endtask

    task automatic push_write(input logic [c_addr_w-1:0] a, input logic [c_data_w-1:0] d);
        int n;
        n = 0;
        bus.host_valid   = 1'b1;
        bus.host_address = a;
        bus.host_data    = d;
        @(negedge clock);
        while (!bus.host_ready && n < 100) begin
            @(negedge clock);
            n++;
        end
        check_value("host_accept", 32'(bus.host_ready), 32'd1);
        @(posedge clock);
        #1;
        bus.host_valid = 1'b0;
    endtask

    task automatic do_burst(input logic [c_addr_w-1:0] base);
        expect_burst(base);
        bus.line_base    = base;
        bus.line_request = 1'b1;
        @(posedge clock);
        #1;
        bus.line_request = 1'b0;
        t_req     = cyc;
        timing_en = (ready_mode == 0);
        check_value("burst_start_read", 32'(bus.mem_read), 32'd1);
        check_value("burst_start_addr", 32'(bus.mem_address), 32'(base));
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((op_q.size() != 0 || pix_q.size() != 0) && n < budget) begin
            @(posedge clock);
            #1;
            n++;
        end
        check_value("queues_drained", 32'(op_q.size() + pix_q.size()), 32'd0);
        op_q.delete();
        pix_q.delete();
        repeat (8) @(posedge clock);
        #1;
        timing_en = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [c_addr_w-1:0] wa [c_depth];
        logic [c_data_w-1:0] wd [c_depth];
        logic [c_addr_w-1:0] a;
        logic [c_data_w-1:0] d;
        int n;

        bus.line_request  = 1'b0;
        bus.line_base     = '0;
        bus.overrun_clear = 1'b0;
        bus.host_valid    = 1'b0;
        bus.host_address  = '0;
        bus.host_data     = '0;
        ready_mode        = 0;

        repeat (3) @(posedge clock);
        #1;
        check_reset_outputs("reset");
        reset = 1'b1;
        @(posedge clock);
        #1;

        // Single host write into an empty FIFO with the FSM idle
        a = c_addr_w'($urandom);
        d = c_data_w'($urandom);
        expect_write(a, d);
        push_write(a, d);
        check_value("wr_latency_early", 32'(bus.mem_write), 32'd0);
        @(posedge clock);
        #1;
        check_value("wr_latency_strobe", 32'(bus.mem_write), 32'd1);
        check_value("wr_latency_addr", 32'(bus.mem_address), 32'(a));
        check_value("wr_latency_data", 32'(bus.mem_write_data), 32'(d));
        wait_idle(50);

        // Basic burst and address wrap
        do_burst(22'h000100);
        wait_idle(100);
        do_burst(22'h3FFFFE);
        wait_idle(100);

        // Stall pattern 1,0,0 on mem_ready
        ready_mode = 1;
        do_burst(c_addr_w'($urandom));
        wait_idle(200);

        // Priority: full FIFO, line request lands on the first write accept
        ready_mode = 3;
        @(posedge clock);
        #1;
        for (int i = 0; i < c_depth; i++) begin
            wa[i] = c_addr_w'($urandom);
            wd[i] = c_data_w'($urandom);
        end
        a = c_addr_w'($urandom);
        expect_write(wa[0], wd[0]);
        expect_burst(a);
        for (int i = 1; i < c_depth; i++) expect_write(wa[i], wd[i]);
        for (int i = 0; i < c_depth; i++) push_write(wa[i], wd[i]);
        check_value("fifo_full_not_ready", 32'(bus.host_ready), 32'd0);
        check_value("head_write_held", 32'(bus.mem_write), 32'd1);
        check_value("head_write_addr", 32'(bus.mem_address), 32'(wa[0]));
        bus.line_base    = a;
        bus.line_request = 1'b1;
        ready_mode       = 0;
        @(posedge clock);
        #1;
        bus.line_request = 1'b0;
        wait_idle(300);
        check_value("fifo_ready_again", 32'(bus.host_ready), 32'd1);

        // Overrun: second request during a burst is dropped and sticky
        ready_mode = 0;
        do_burst(c_addr_w'($urandom));
        repeat (2) @(posedge clock);
        #1;
        bus.line_base    = c_addr_w'($urandom);
        bus.line_request = 1'b1;
        @(posedge clock);
        #1;
        bus.line_request = 1'b0;
        check_value("overrun_set", 32'(bus.line_overrun), 32'd1);
        wait_idle(200);
        check_value("overrun_sticky", 32'(bus.line_overrun), 32'd1);
        bus.overrun_clear = 1'b1;
        @(posedge clock);
        #1;
        bus.overrun_clear = 1'b0;
        check_value("overrun_cleared", 32'(bus.line_overrun), 32'd0);
        do_burst(c_addr_w'($urandom));
        repeat (2) @(posedge clock);
        #1;
        bus.line_base     = c_addr_w'($urandom);
        bus.line_request  = 1'b1;
        bus.overrun_clear = 1'b1;
        @(posedge clock);
        #1;
        bus.line_request  = 1'b0;
        bus.overrun_clear = 1'b0;
        check_value("overrun_clear_wins", 32'(bus.line_overrun), 32'd0);
        wait_idle(200);

        // Asynchronous reset at pixel 3 of a burst
        seen_pix3 = 1'b0;
        do_burst(c_addr_w'($urandom));
        n = 0;
        while (!seen_pix3 && n < 100) begin
            @(posedge clock);
            #1;
            n++;
        end
        check_value("reached_pixel3", 32'(seen_pix3), 32'd1);
        reset = 1'b0;
        op_q.delete();
        pix_q.delete();
        timing_en = 1'b0;
        #1;
        check_reset_outputs("midburst_reset");
        @(posedge clock);
        #1;
        reset = 1'b1;
        repeat (6) @(posedge clock);
        #1;
        do_burst(c_addr_w'($urandom));
        wait_idle(100);

        // Randomised mix: queued writes, then a burst, random ready
        for (int it = 0; it < 6; it++) begin
            ready_mode = $urandom_range(0, 2);
            n = $urandom_range(0, 3);
            for (int k = 0; k < n; k++) begin
                a = c_addr_w'($urandom);
                d = c_data_w'($urandom);
                expect_write(a, d);
                push_write(a, d);
            end
            wait_idle(200);
            a = (it == 3) ? 22'h3FFFFB : c_addr_w'($urandom);
            do_burst(a);
            wait_idle(400);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
